mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit_pkg.sv | 23 ++
 rtl/mdu_arith.sv | 55 +++++
 rtl/mult_div_unit.sv | 90 +++++++++
 3 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared MIPS multiply/divide constants: OpE encodings, default latencies
// and small decode helpers used by the MDU, the start control and the decoder.
package mult_div_unit_pkg;

  typedef logic [1:0] mdu_op_t;

  localparam mdu_op_t OP_MULT  = 2'b00;
  localparam mdu_op_t OP_MULTU = 2'b01;
  localparam mdu_op_t OP_DIV   = 2'b10;
  localparam mdu_op_t OP_DIVU  = 2'b11;

  localparam int MULT_CYCLES_DEFAULT = 5;
  localparam int DIV_CYCLES_DEFAULT  = 10;

  function automatic logic op_is_div(input mdu_op_t op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input mdu_op_t op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit multiply / divide datapath for the MDU.
// Division works on magnitudes so signed and unsigned share one divider.
module mdu_arith
  import mult_div_unit_pkg::*;
(
  input  logic [1:0]  OpE,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero
);

  logic        sgn;
  logic        a_neg;
  logic        b_neg;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] divisor;
  logic [31:0] q_mag;
  logic [31:0] r_mag;

  always_comb begin
    sgn   = op_is_signed(OpE);
    a_neg = sgn & SrcAE[31];
    b_neg = sgn & SrcBE[31];

    // Low 64 bits of the product of the sign-extended operands are exact
    // for both signed and unsigned multiplies.
    a_ext = {{32{a_neg}}, SrcAE};
    b_ext = {{32{b_neg}}, SrcBE};
    prod  = a_ext * b_ext;

    a_mag = a_neg ? -SrcAE : SrcAE;
    b_mag = b_neg ? -SrcBE : SrcBE;

    div_by_zero = op_is_div(OpE) && (SrcBE == 32'd0);
    // Substitute divisor keeps the divider well defined; result is discarded.
    divisor = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag   = a_mag / divisor;
    r_mag   = a_mag % divisor;

    if (op_is_div(OpE)) begin
      lo = (a_neg ^ b_neg) ? -q_mag : q_mag;
      hi = a_neg ? -r_mag : r_mag;
    end else begin
      hi = prod[63:32];
      lo = prod[31:0];
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// MIPS HI/LO multiply-divide unit: result computed at start, held pending,
// and committed to HI/LO after a fixed per-operation latency.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        StartE,
  input  logic [1:0]  OpE,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  input  logic        HiWriteE,
  input  logic        LoWriteE,
  output logic        Busy,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state_reg;
  logic [CNT_W-1:0] count_reg;
  logic [31:0]      pend_hi_reg;
  logic [31:0]      pend_lo_reg;
  logic             pend_keep_reg;

  logic [31:0]      arith_hi;
  logic [31:0]      arith_lo;
  logic             arith_dbz;
  logic [CNT_W-1:0] latency;

  mdu_arith u_arith (
    .OpE         (OpE),
    .SrcAE       (SrcAE),
    .SrcBE       (SrcBE),
    .hi          (arith_hi),
    .lo          (arith_lo),
    .div_by_zero (arith_dbz)
  );

  assign latency = op_is_div(OpE) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
  assign Busy    = (state_reg == ST_RUN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      count_reg     <= '0;
      pend_hi_reg   <= '0;
      pend_lo_reg   <= '0;
      pend_keep_reg <= 1'b0;
      Hi            <= '0;
      Lo            <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          // MT writes land now; a coinciding operation overwrites at commit.
          if (HiWriteE) Hi <= SrcAE;
          if (LoWriteE) Lo <= SrcAE;
          if (StartE) begin
            pend_hi_reg   <= arith_hi;
            pend_lo_reg   <= arith_lo;
            pend_keep_reg <= arith_dbz;
            count_reg     <= latency;
            state_reg     <= ST_RUN;
          end
        end
        default: begin
          if (count_reg <= CNT_W'(1)) begin
            if (!pend_keep_reg) begin
              Hi <= pend_hi_reg;
              Lo <= pend_lo_reg;
            end
            count_reg <= '0;
            state_reg <= ST_IDLE;
          end else begin
            count_reg <= count_reg - CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule
